pong_game_ctrl: RTL and testbench

Parametrised game-state controller for the pong display pipeline. It sequences attract/serve/play/game-over phases, tracks score and remaining lives, and times the serve delay and game-over hold in video frames. It also produces the pixel-registered RGB output by muxing graph, text overlay and background. It sits between the debounced buttons, the pong graphics engine (which consumes `graph_still` and `ball_reset` and returns `hit`/`miss`) and the VGA pins.

---
 rtl/pong_game_ctrl.sv | 125 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game-phase sequencer (attract/serve/play/game-over) with score,
// lives, frame-timed serve delay and game-over hold, plus the registered RGB pixel mux.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   btn[N_BTN]            debounced buttons; any 0->1 bit starts a game from NEW
//   hit, miss             one-cycle pulses from the graphics engine
//   frame_tick            one pulse per video frame (serve / game-over timing)
//   pixel_tick            pixel-rate enable for the rgb register
//   video_on, graph_on, graph_rgb, text_on, text_rgb   pixel sources
//   graph_still, ball_reset, state   Moore outputs decoded from the state register
//   score, lives_left     game counters
//   rgb                   registered pixel colour
module pong_game_ctrl #(
    parameter int N_BTN        = 4,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 4,
    parameter int SCORE_MAX    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 120,
    parameter int RGB_W        = 3,
    parameter logic [RGB_W-1:0] BG_RGB = 3'b110,
    localparam int LIV_W = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn,
    input  logic               hit,
    input  logic               miss,
    input  logic               frame_tick,
    input  logic               pixel_tick,
    input  logic               video_on,
    input  logic               graph_on,
    input  logic [RGB_W-1:0]   graph_rgb,
    input  logic               text_on,
    input  logic [RGB_W-1:0]   text_rgb,
    output logic               graph_still,
    output logic               ball_reset,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [LIV_W-1:0]   lives_left,
    output logic [RGB_W-1:0]   rgb
);
    localparam int TMAX  = SERVE_FRAMES > OVER_FRAMES ? SERVE_FRAMES : OVER_FRAMES;
    localparam int TMR_W = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam logic [TMR_W-1:0]   SERVE_LAST = TMR_W'(SERVE_FRAMES - 1);
    localparam logic [TMR_W-1:0]   OVER_LAST  = TMR_W'(OVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

    typedef enum logic [1:0] {NEW = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIV_W-1:0]   lives_q, lives_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic [N_BTN-1:0]   btn_prev_q;
    logic               start;

    // previous-btn resets to all ones so buttons held through reset never look like a press
    assign start = |(btn & ~btn_prev_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NEW;
            score_q    <= '0;
            lives_q    <= LIV_W'(LIVES);
            tmr_q      <= '0;
            rgb_q      <= '0;
            btn_prev_q <= '1;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            tmr_q      <= tmr_d;
            rgb_q      <= rgb_d;
            btn_prev_q <= btn;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        tmr_d   = tmr_q;
        case (state_q)
            NEW: if (start) begin
                state_d = SERVE;
                score_d = '0;
                lives_d = LIV_W'(LIVES);
                tmr_d   = '0;
            end
            SERVE: if (frame_tick) begin
                state_d = tmr_q == SERVE_LAST ? PLAY : SERVE;
                tmr_d   = tmr_q == SERVE_LAST ? '0 : tmr_q + TMR_W'(1);
            end
            PLAY: begin
                if (hit && score_q != SCORE_TOP)
                    score_d = score_q + SCORE_W'(1);
                if (miss) begin
                    lives_d = lives_q - LIV_W'(1);
                    tmr_d   = '0;
                    state_d = lives_q == LIV_W'(1) ? OVER : SERVE;
                end
            end
            default: if (frame_tick) begin
                state_d = tmr_q == OVER_LAST ? NEW : OVER;
                tmr_d   = tmr_q == OVER_LAST ? '0 : tmr_q + TMR_W'(1);
            end
        endcase
    end

    always_comb begin
        graph_still = state_q != PLAY;
        ball_reset  = state_q == NEW || state_q == SERVE;
        state       = state_q;
        score       = score_q;
        lives_left  = lives_q;
        rgb         = rgb_q;
        // text overlay only wins on the attract and game-over screens
        rgb_d = !pixel_tick ? rgb_q :
                !video_on ? '0 :
                (text_on && (state_q == NEW || state_q == OVER)) ? text_rgb :
                graph_on ? graph_rgb : BG_RGB;
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;
    logic       clk = 0;
    logic       reset = 1;
    logic [3:0] btn = 4'b0001;
    logic       hit = 0, miss = 0, frame_tick = 0, pixel_tick = 0;
    logic       video_on = 0, graph_on = 0, text_on = 0;
    logic [2:0] graph_rgb = 3'b101, text_rgb = 3'b011;
    logic       graph_still, ball_reset;
    logic [1:0] state;
    logic [3:0] score;
    logic [1:0] lives_left;
    logic [2:0] rgb;
    int checks = 0, errors = 0;

    pong_game_ctrl #(.SERVE_FRAMES(2), .OVER_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .btn(btn), .hit(hit), .miss(miss),
        .frame_tick(frame_tick), .pixel_tick(pixel_tick), .video_on(video_on),
        .graph_on(graph_on), .graph_rgb(graph_rgb), .text_on(text_on), .text_rgb(text_rgb),
        .graph_still(graph_still), .ball_reset(ball_reset), .state(state),
        .score(score), .lives_left(lives_left), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1; step(); frame_tick = 0; step();
        end
    endtask

    task automatic test_reset;
        step(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL rst_score got %0d exp 0", score); end
        checks++; if (lives_left !== 2'd3) begin errors++; $display("FAIL rst_lives got %0d exp 3", lives_left); end
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rst_rgb got %0d exp 0", rgb); end
        checks++; if ({graph_still, ball_reset} !== 2'b11) begin errors++; $display("FAIL rst_moore got %b exp 11", {graph_still, ball_reset}); end
        reset = 0; step(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_btn_no_start got %0d exp 0", state); end
        btn = 0; step(); btn = 4'b0001; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", state); end
        checks++; if ({score, lives_left} !== {4'd0, 2'd3}) begin errors++; $display("FAIL start_counters got %0d/%0d exp 0/3", score, lives_left); end
    endtask

    task automatic test_serve_delay;
        frames(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL serve_one_tick got %0d exp 1", state); end
        frame_tick = 1; step(); frame_tick = 0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL serve_to_play got %0d exp 2", state); end
        checks++; if ({graph_still, ball_reset} !== 2'b00) begin errors++; $display("FAIL play_moore got %b exp 00", {graph_still, ball_reset}); end
    endtask

    task automatic test_score_sat;
        frame_tick = 1; step(); frame_tick = 0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL play_ignores_frame got %0d exp 2", state); end
        for (int i = 0; i < 12; i++) begin hit = 1; step(); end
        hit = 0; step();
        checks++; if (score !== 4'd9) begin errors++; $display("FAIL score_sat got %0d exp 9", score); end
        hit = 1; miss = 1; step(); hit = 0; miss = 0;
        checks++; if ({state, score, lives_left} !== {2'd1, 4'd9, 2'd2}) begin errors++; $display("FAIL hit_miss got s%0d sc%0d l%0d exp s1 sc9 l2", state, score, lives_left); end
    endtask

    task automatic test_full_game;
        frames(2); miss = 1; step(); miss = 0;
        checks++; if ({state, lives_left} !== {2'd1, 2'd1}) begin errors++; $display("FAIL second_miss got s%0d l%0d exp s1 l1", state, lives_left); end
        frames(2); miss = 1; step(); miss = 0;
        checks++; if ({state, lives_left} !== {2'd3, 2'd0}) begin errors++; $display("FAIL third_miss got s%0d l%0d exp s3 l0", state, lives_left); end
        checks++; if ({graph_still, ball_reset} !== 2'b10) begin errors++; $display("FAIL over_moore got %b exp 10", {graph_still, ball_reset}); end
        btn = 0; step(); btn = 4'b0010; hit = 1; step(); hit = 0;
        checks++; if ({state, score} !== {2'd3, 4'd9}) begin errors++; $display("FAIL over_frozen got s%0d sc%0d exp s3 sc9", state, score); end
        frames(2);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_hold got %0d exp 3", state); end
        frames(1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL over_to_new got %0d exp 0", state); end
    endtask

    task automatic test_rgb;
        pixel_tick = 1; video_on = 0; text_on = 1; graph_on = 1; step();
        checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL rgb_blank got %b exp 000", rgb); end
        video_on = 1; step();
        checks++; if (rgb !== 3'b011) begin errors++; $display("FAIL rgb_text_new got %b exp 011", rgb); end
        text_on = 0; graph_on = 0; step();
        checks++; if (rgb !== 3'b110) begin errors++; $display("FAIL rgb_bg got %b exp 110", rgb); end
        pixel_tick = 0; text_on = 1; step(2);
        checks++; if (rgb !== 3'b110) begin errors++; $display("FAIL rgb_hold got %b exp 110", rgb); end
        btn = 0; step(); btn = 4'b1000; step(); frames(2);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rgb_to_play got %0d exp 2", state); end
        pixel_tick = 1; graph_on = 1; step();
        checks++; if (rgb !== 3'b101) begin errors++; $display("FAIL rgb_graph_play got %b exp 101", rgb); end
        graph_on = 0; step();
        checks++; if (rgb !== 3'b110) begin errors++; $display("FAIL rgb_text_ignored_play got %b exp 110", rgb); end
        pixel_tick = 0;
    endtask

    task automatic test_reset_mid_play;
        for (int i = 0; i < 5; i++) begin hit = 1; step(); end
        hit = 0; miss = 1; step(); miss = 0; frames(2);
        miss = 1; step(); miss = 0; frames(2);
        checks++; if ({state, score, lives_left} !== {2'd2, 4'd5, 2'd1}) begin errors++; $display("FAIL mid_setup got s%0d sc%0d l%0d exp s2 sc5 l1", state, score, lives_left); end
        reset = 1; step(); reset = 0;
        checks++; if ({state, score, lives_left, rgb} !== {2'd0, 4'd0, 2'd3, 3'd0}) begin errors++; $display("FAIL mid_reset got s%0d sc%0d l%0d rgb%b exp s0 sc0 l3 rgb000", state, score, lives_left, rgb); end
    endtask

    initial begin
        test_reset();
        test_serve_delay();
        test_score_sat();
        test_full_game();
        test_rgb();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
